// File: rtl/i2c_target_ctrl_pkg.sv
// i2c_target_ctrl_pkg: shared state encoding, bus constants and helpers for the I2C target.
package i2c_target_ctrl_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam logic ACK = 1'b0;
    localparam logic NACK = 1'b1;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } tgt_state_e;
    function automatic logic maj3(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/i2c_target_ctrl_if.sv
// i2c_target_ctrl_if: pad lines, host read port and status of the I2C target.
interface i2c_target_ctrl_if #(parameter int REG_DEPTH = 16);
    localparam int PTR_W = $clog2(REG_DEPTH);
    logic scl_i;
    logic sda_i;
    logic sda_oe;
    logic [PTR_W-1:0] host_addr;
    logic [7:0] host_rdata;
    logic start_det;
    logic stop_det;
    logic busy;
    modport slave (
        input scl_i, sda_i, host_addr,
        output sda_oe, host_rdata, start_det, stop_det, busy
    );
    modport master (
        output scl_i, sda_i, host_addr,
        input sda_oe, host_rdata, start_det, stop_det, busy
    );
endinterface

// File: rtl/i2c_target_ctrl_line_sync.sv
// i2c_target_ctrl_line_sync: pad synchronizers and scl edge / START / STOP pulses.
// I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter on both lines.
module i2c_target_ctrl_line_sync
    import i2c_target_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);
    logic [1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q, scl_f, sda_f;
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end
`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_win_q, sda_win_q;
    logic scl_flt_q, sda_flt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_win_q <= 2'b11;
            sda_win_q <= 2'b11;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_win_q <= {scl_win_q[0], scl_sync_q[1]};
            sda_win_q <= {sda_win_q[0], sda_sync_q[1]};
            scl_flt_q <= maj3(scl_sync_q[1], scl_win_q[0], scl_win_q[1]);
            sda_flt_q <= maj3(sda_sync_q[1], sda_win_q[0], sda_win_q[1]);
        end
    end
    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end
    assign scl_rise = scl_f & ~scl_prev_q;
    assign scl_fall = ~scl_f & scl_prev_q;
    assign sda_s = sda_f;
    assign start = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
endmodule

// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl: I2C target with address match, register pointer and auto-incrementing register bank.
// Build with I2C_TGT_GLITCH_FILTER_EN to enable the line glitch filter.
module i2c_target_ctrl
    import i2c_target_ctrl_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TGT_ADDR = 7'h50,
    parameter int REG_DEPTH = 16
) (
    input logic clk,
    input logic reset,
    i2c_target_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(REG_DEPTH);
    logic scl_rise, scl_fall, sda_s, start, stop;
    tgt_state_e state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d, byte_in;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic [I2C_BYTE_W-1:0] regs_q [REG_DEPTH];
    logic sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d, start_q, stop_q, wr_en;
    i2c_target_ctrl_line_sync u_sync (
        .clk(clk),
        .reset(reset),
        .scl_i(bus.scl_i),
        .sda_i(bus.sda_i),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .sda_s(sda_s),
        .start(start),
        .stop(stop)
    );
    assign byte_in = {shift_q[I2C_BYTE_W-2:0], sda_s};
    assign ptr_inc = ptr_q + PTR_W'(1);
    // sda_oe only moves on scl_fall; ACK states pull low for the whole 9th clock
    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        ptr_d = ptr_q;
        sda_oe_d = sda_oe_q;
        busy_d = busy_q;
        rw_d = rw_q;
        wr_en = 1'b0;
        if (start) begin
            state_d = ADDR;
            bit_d = '0;
            sda_oe_d = 1'b0;
            busy_d = 1'b1;
        end else if (stop) begin
            state_d = IDLE;
            bit_d = '0;
            sda_oe_d = 1'b0;
            busy_d = 1'b0;
        end else if (scl_fall) begin
            sda_oe_d = (state_q inside {ADDR_ACK, PTR_ACK, WR_ACK}) ? ~ACK :
                       (state_q == RD_DATA) ? ~shift_q[I2C_BYTE_W-1] : 1'b0;
        end else if (scl_rise) begin
            bit_d = bit_q + 3'd1;
            shift_d = byte_in;
            case (state_q)
                ADDR: if (bit_q == 3'd7) begin
                    rw_d = sda_s;
                    state_d = (byte_in[7:1] == TGT_ADDR && TGT_ADDR != '0) ? ADDR_ACK : IGNORE;
                end
                ADDR_ACK: begin
                    bit_d = '0;
                    shift_d = regs_q[ptr_q];
                    state_d = rw_q ? RD_DATA : PTR;
                end
                PTR: if (bit_q == 3'd7) begin
                    ptr_d = byte_in[PTR_W-1:0];
                    state_d = PTR_ACK;
                end
                PTR_ACK, WR_ACK: begin
                    bit_d = '0;
                    state_d = WR_DATA;
                end
                WR_DATA: if (bit_q == 3'd7) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_inc;
                    state_d = WR_ACK;
                end
                RD_DATA: if (bit_q == 3'd7) state_d = RD_ACK;
                RD_ACK: begin
                    bit_d = '0;
                    ptr_d = ptr_inc;
                    shift_d = regs_q[ptr_inc];
                    state_d = (sda_s == NACK) ? IGNORE : RD_DATA;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q <= '0;
            shift_q <= '0;
            ptr_q <= '0;
            sda_oe_q <= 1'b0;
            busy_q <= 1'b0;
            rw_q <= 1'b0;
            start_q <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            ptr_q <= ptr_d;
            sda_oe_q <= sda_oe_d;
            busy_q <= busy_d;
            rw_q <= rw_d;
            start_q <= start;
            stop_q <= stop;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else if (wr_en) regs_q[ptr_q] <= byte_in;
    end
    assign bus.sda_oe = sda_oe_q;
    assign bus.host_rdata = regs_q[bus.host_addr];
    assign bus.start_det = start_q;
    assign bus.stop_det = stop_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_i2c_target_ctrl.sv
// tb_i2c_target_ctrl: bit-banged I2C master with a register-bank reference model.
module tb_i2c_target_ctrl;
    localparam int Q = 6;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_stop = 0;
    int oe_cnt = 0;
    logic [7:0] mdl_regs [16];
    int mdl_ptr = 0;
    logic [7:0] dq[$];
    logic [6:0] ra;
    logic ack;
    logic b0;
    int k;

    i2c_target_ctrl_if #(.REG_DEPTH(16)) bus();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    i2c_target_ctrl #(.TGT_ADDR(7'h50), .REG_DEPTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.start_det) n_start++;
        if (bus.stop_det) n_stop++;
        if (bus.sda_oe) oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(2 * Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        b = bus.sda_i;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic do_start();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic do_stop();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) get_bit(b[i]);
        put_bit(nack);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.host_addr = 4'(i);
            #1;
            chk(tag, bus.host_rdata, mdl_regs[i]);
        end
    endtask

    task automatic wr_txn(input logic [6:0] a, input logic [7:0] p, input logic [7:0] d[$]);
        logic hit, ak;
        int s0, o0;
        hit = (a == 7'h50);
        s0 = n_stop;
        o0 = oe_cnt;
        do_start();
        write_byte({a, 1'b0}, ak);
        chk("addr_ack", ak, hit ? 0 : 1);
        write_byte(p, ak);
        if (hit) begin
            chk("ptr_ack", ak, 0);
            mdl_ptr = int'(p) % 16;
            foreach (d[i]) begin
                write_byte(d[i], ak);
                chk("wr_ack", ak, 0);
                mdl_regs[mdl_ptr] = d[i];
                mdl_ptr = (mdl_ptr + 1) % 16;
            end
        end else begin
            chk("ign_oe", oe_cnt - o0, 0);
        end
        chk("busy_in_txn", bus.busy, 1);
        do_stop();
        tick(8);
        chk("busy_after_stop", bus.busy, 0);
        chk("stop_pulse", n_stop - s0, 1);
    endtask

    task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
        logic ak;
        logic [7:0] b;
        int s0;
        s0 = n_start;
        do_start();
        if (set_ptr) begin
            write_byte(8'hA0, ak);
            chk("rd_waddr_ack", ak, 0);
            write_byte(p, ak);
            chk("rd_ptr_ack", ak, 0);
            mdl_ptr = int'(p) % 16;
            do_start();
        end
        write_byte(8'hA1, ak);
        chk("rd_addr_ack", ak, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i == n - 1);
            chk("rd_data", b, mdl_regs[mdl_ptr]);
            mdl_ptr = (mdl_ptr + 1) % 16;
        end
        do_stop();
        tick(8);
        chk("start_pulses", n_start - s0, set_ptr ? 2 : 1);
        chk("rd_busy_idle", bus.busy, 0);
    endtask

    initial begin
        foreach (mdl_regs[i]) mdl_regs[i] = 8'h00;
        bus.host_addr = '0;
        tick(4);
        reset = 1'b0;
        tick(4);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start_det", bus.start_det, 0);
        chk("rst_stop_det", bus.stop_det, 0);
        chk_regs("rst_reg");

        wr_txn(7'h50, 8'h03, '{8'hA5});
        bus.host_addr = 4'd3;
        #1;
        chk("reg3_a5", bus.host_rdata, 8'hA5);
        rd_txn(1'b1, 8'h03, 2);
        rd_txn(1'b0, 8'h00, 1);

        wr_txn(7'h51, 8'h07, '{});
        chk_regs("after_mismatch");

        wr_txn(7'h50, 8'h0F, '{8'h11, 8'h22});
        chk_regs("after_wrap");
        rd_txn(1'b0, 8'h00, 1);

        do_start();
        write_byte(8'hA0, ack);
        chk("part_addr_ack", ack, 0);
        write_byte(8'h02, ack);
        chk("part_ptr_ack", ack, 0);
        mdl_ptr = 2;
        repeat (4) put_bit(1'b1);
        do_stop();
        tick(8);
        chk("part_sda_oe", bus.sda_oe, 0);
        chk("part_busy", bus.busy, 0);
        chk_regs("part_reg");
        rd_txn(1'b0, 8'h00, 1);

        for (int t = 0; t < 14; t++) begin
            k = $urandom_range(0, 2);
            dq.delete();
            if (k == 0) begin
                repeat ($urandom_range(1, 4)) dq.push_back(8'($urandom));
                wr_txn(7'h50, 8'($urandom), dq);
            end else if (k == 1) begin
                rd_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3));
            end else begin
                ra = 7'($urandom);
                if (ra == 7'h50) ra = 7'h51;
                wr_txn(ra, 8'($urandom), dq);
            end
        end
        chk_regs("rand_reg");

        wr_txn(7'h50, 8'h03, '{8'hA5});
        do_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        do_start();
        write_byte(8'hA1, ack);
        chk("rst_rd_addr_ack", ack, 0);
        get_bit(b0);
        chk("rst_rd_bit7", b0, 1);
        chk("rst_rd_oe_on", bus.sda_oe, 1);
        reset = 1'b1;
        tick(1);
        chk("midrst_sda_oe", bus.sda_oe, 0);
        chk("midrst_busy", bus.busy, 0);
        foreach (mdl_regs[i]) mdl_regs[i] = 8'h00;
        mdl_ptr = 0;
        chk_regs("midrst_reg");
        reset = 1'b0;
        m_sda = 1'b1;
        m_scl = 1'b1;
        tick(8);
        wr_txn(7'h50, 8'h01, '{8'h5A, 8'hC3});
        rd_txn(1'b1, 8'h01, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
